// File: rtl/inst_fetch.sv
// Instruction fetch: PC register + in-order {pc,inst} queue to decode; optional INST_FETCH_MISALIGN_TRAP_EN.
// Latency: word addressed in cycle N is valid at o_valid in N+1; redirect target valid two cycles after redirect.
// Backpressure: queue absorbs up to DEPTH words, then PC holds until decode pops (push+pop allowed when full).
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_inst,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_valid,
    output logic [31:0]       o_inst,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_ready,
    output logic              o_misalign,
    output logic [ADDR_W-1:0] o_misalign_pc
);

    localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL  = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] tgt;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [31:0]       q_inst [DEPTH];
    logic              halt;
    logic              push;
    logic              pop;

`ifdef INST_FETCH_MISALIGN_TRAP_EN
    logic              mis_q;
    logic [ADDR_W-1:0] mis_pc_q;

    assign tgt  = i_redirect_pc;
    assign halt = mis_q;

    // Any redirect re-evaluates the trap; only misaligned targets overwrite the captured PC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mis_q    <= 1'b0;
            mis_pc_q <= '0;
        end else if (i_redirect) begin
            mis_q <= |i_redirect_pc[1:0];
            if (|i_redirect_pc[1:0]) begin
                mis_pc_q <= i_redirect_pc;
            end
        end
    end

    assign o_misalign    = mis_q;
    assign o_misalign_pc = mis_pc_q;
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
    assign tgt           = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    assign halt          = 1'b0;
    assign o_misalign    = 1'b0;
    assign o_misalign_pc = '0;
`endif

    assign o_imem_addr = pc_q;
    assign o_valid     = (count != '0) && !i_redirect;
    assign o_inst      = q_inst[rd_ptr];
    assign o_pc        = q_pc[rd_ptr];
    assign pop         = o_valid && i_ready;
    assign push        = !i_redirect && !halt && ((count < FULL) || pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q   <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_redirect) begin
            pc_q   <= tgt;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_q   <= pc_q + ADDR_W'(4);
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head fields are never X.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else if (push) begin
            q_pc[wr_ptr]   <= pc_q;
            q_inst[wr_ptr] <= i_imem_inst;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_inst, redir_pc, o_pc, mis_pc;
    logic        redirect, ready, o_valid, mis;
    logic [31:0] o_inst;

    logic [7:0]  imem_addr8, redir_pc8, o_pc8, mis_pc8;
    logic [31:0] imem_inst8, o_inst8;
    logic        redirect8, o_valid8, mis8;

    int errors = 0;
    int checks = 0;

    // Behavioural model: queue of fetched PCs, next fetch address, trap state.
    logic [31:0] mq[$];
    logic [31:0] mpc;
    logic        mhalt;
    logic [31:0] mmis_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a >> 2);
    endfunction

    function automatic logic [31:0] memword8(input logic [7:0] a);
        return 32'h5A00_0000 | {24'h0, a};
    endfunction

    assign imem_inst  = memword(imem_addr);
    assign imem_inst8 = memword8(imem_addr8);

    inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr), .i_imem_inst(imem_inst),
        .i_redirect(redirect), .i_redirect_pc(redir_pc), .o_valid(o_valid), .o_inst(o_inst),
        .o_pc(o_pc), .i_ready(ready), .o_misalign(mis), .o_misalign_pc(mis_pc)
    );

    inst_fetch #(.ADDR_W(8), .RESET_PC(8'h0), .DEPTH(DEPTH)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr8), .i_imem_inst(imem_inst8),
        .i_redirect(redirect8), .i_redirect_pc(redir_pc8), .o_valid(o_valid8), .o_inst(o_inst8),
        .o_pc(o_pc8), .i_ready(1'b1), .o_misalign(mis8), .o_misalign_pc(mis_pc8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc     = 32'h0;
        mhalt   = 1'b0;
        mmis_pc = 32'h0;
    endtask

    task automatic model_step();
        bit do_pop, do_push;
        if (!rst_n) begin
            model_reset();
        end else if (redirect) begin
            mq.delete();
`ifdef INST_FETCH_MISALIGN_TRAP_EN
            mpc = redir_pc;
            if (redir_pc[1:0] != 2'b00) begin
                mhalt   = 1'b1;
                mmis_pc = redir_pc;
            end else begin
                mhalt = 1'b0;
            end
`else
            mpc = redir_pc & ~32'h3;
`endif
        end else begin
            do_pop  = (mq.size() != 0) && ready;
            do_push = !mhalt && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        bit exp_valid;
        exp_valid = rst_n && (mq.size() != 0) && !redirect;
        chk("valid", o_valid, exp_valid);
        chk("imem_addr", imem_addr, mpc);
        if (exp_valid) begin
            chk("head_pc", o_pc, mq[0]);
            chk("head_inst", o_inst, memword(mq[0]));
        end
        if (!rst_n) begin
            chk("reset_pc_out", o_pc, 0);
            chk("reset_inst_out", o_inst, 0);
        end
        chk("misalign", mis, mhalt);
        chk("misalign_pc", mis_pc, mmis_pc);
    endtask

    // Compare at the falling edge, advance model at the rising edge, return just after it.
    task automatic cyc();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redir_pc = 32'h0;
        redirect8 = 1'b0; redir_pc8 = 8'h0;
        model_reset();
        cyc(); cyc();
        chk("lit_reset_valid", o_valid, 0);
        chk("lit_reset_addr", imem_addr, 32'h0);
        chk("lit_reset_mis", mis, 0);

        // Streaming from reset: one instruction per cycle starting at 0x0.
        rst_n = 1'b1;
        cyc();
        chk("lit_first_valid", o_valid, 1);
        chk("lit_first_pc", o_pc, 32'h0);
        chk("lit_first_inst", o_inst, 32'hC0DE_0000);
        chk("lit_first_addr", imem_addr, 32'h4);
        cyc(); chk("lit_stream_pc1", o_pc, 32'h4);
        cyc(); chk("lit_stream_pc2", o_pc, 32'h8);
        cyc(); chk("lit_stream_pc3", o_pc, 32'hC);

        // One stall fills the queue, then redirect with ready=1 voids the pop.
        ready = 1'b0;
        cyc();
        ready = 1'b1; redirect = 1'b1; redir_pc = 32'h100;
        #1 chk("lit_redir_mask", o_valid, 0);
        cyc();
        redirect = 1'b0;
        chk("lit_redir_addr", imem_addr, 32'h100);
        chk("lit_redir_bubble", o_valid, 0);
        cyc();
        chk("lit_redir_valid", o_valid, 1);
        chk("lit_redir_pc", o_pc, 32'h100);
        cyc();

        // Back-to-back redirects: last wins.
        redirect = 1'b1; redir_pc = 32'h200;
        cyc();
        redir_pc = 32'h300;
        cyc();
        redirect = 1'b0;
        chk("lit_b2b_addr", imem_addr, 32'h300);
        cyc();
        chk("lit_b2b_pc", o_pc, 32'h300);

        // 8-bit PC wrap on the second instance.
        redirect8 = 1'b1; redir_pc8 = 8'hFC;
        cyc();
        redirect8 = 1'b0;
        cyc();
        chk("lit_wrap_pc_fc", o_pc8, 8'hFC);
        cyc();
        chk("lit_wrap_pc_00", o_pc8, 8'h00);
        chk("lit_wrap_inst_00", o_inst8, 32'h5A00_0000);

        // Misaligned redirect target.
        redirect = 1'b1; redir_pc = 32'h102;
        cyc();
        redirect = 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        chk("lit_mis_flag", mis, 1);
        chk("lit_mis_pc", mis_pc, 32'h102);
        cyc(); cyc();
        chk("lit_mis_halt", o_valid, 0);
        redirect = 1'b1; redir_pc = 32'h200;
        cyc();
        redirect = 1'b0;
        chk("lit_mis_clear", mis, 0);
        cyc();
        chk("lit_mis_resume", o_pc, 32'h200);
`else
        chk("lit_align_addr", imem_addr, 32'h100);
        cyc();
        chk("lit_align_pc", o_pc, 32'h100);
        chk("lit_align_mis", mis, 0);
`endif
        cyc(); cyc();

        // Asynchronous reset mid-stream, then stall from reset.
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("lit_areset_valid", o_valid, 0);
        chk("lit_areset_addr", imem_addr, 32'h0);
        chk("lit_areset_pc", o_pc, 32'h0);
        chk("lit_areset_inst", o_inst, 32'h0);
        ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("lit_stall_addr", imem_addr, 32'h8);
        chk("lit_stall_pc", o_pc, 32'h0);

        // Drain while full: simultaneous push/pop, order preserved.
        ready = 1'b1;
        cyc(); chk("lit_drain_pc1", o_pc, 32'h4);
        cyc(); chk("lit_drain_pc2", o_pc, 32'h8);
        for (int i = 0; i < 6; i++) cyc();
        chk("lit_drain_pc8", o_pc, 32'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the instruction memory. Holds the program counter and drives the memory's byte address. Captures the returned word together with its PC into a small in-order queue, and hands entries to the decode stage over a valid/ready handshake. Supports redirects (branch/jump/trap targets) that flush all buffered instructions.

## Interface
Parameters:
- `ADDR_W`, 32, PC/address width in bits.
- `RESET_PC`, 0, PC value loaded on reset; must be word-aligned.
- `DEPTH`, 2, fetch queue entries; power of two, ≥ 2.

Ports:
- `i_clk`  in  1  clock, rising-edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `o_imem_addr`  out  ADDR_W  byte address to instruction memory; equals the PC register.
- `i_imem_inst`  in  32  instruction word, combinational response to `o_imem_addr` in the same cycle.
- `i_redirect`  in  1  load a new PC and flush the queue.
- `i_redirect_pc`  in  ADDR_W  redirect target.
- `o_valid`  out  1  queue head valid toward decode.
- `o_inst`  out  32  queue head instruction.
- `o_pc`  out  ADDR_W  PC of the queue head.
- `i_ready`  in  1  decode accepts the head this cycle.
- `o_misalign`  out  1  misaligned redirect trap pending (see Configuration).
- `o_misalign_pc`  out  ADDR_W  offending redirect target.

## Operation
- State:
  - `pc_q` (ADDR_W bits).
  - Circular queue of DEPTH × {pc, inst} with rd/wr pointers and a count 0..DEPTH.
  - Misalign flag/PC (only when the macro is enabled).
- `pop` = `o_valid && i_ready`.
- `push` = `!i_redirect && !halt && (count < DEPTH || pop)`.
  - `halt` is the misalign flag; it is constant 0 when the feature is compiled out.
- On push:
  - Write {`pc_q`, `i_imem_inst`} at the wr pointer.
  - `pc_q <= pc_q + 4`, modulo 2^ADDR_W (wraps from all-ones−3 to 0).
- On pop: advance the rd pointer.
- Count update:
  - Push and pop together leave count unchanged. This is legal when full.
  - Otherwise count increments on push and decrements on pop.
- Redirect (`i_redirect`=1) has priority over everything:
  - Count and pointers reset to 0.
  - `pc_q <= target`.
  - No push that cycle.
  - A pop that cycle is void: `o_valid` is masked to 0 while `i_redirect`=1, so decode never sees a handshake.
- `o_valid = (count != 0) && !i_redirect`.
- `o_inst` and `o_pc` show the head entry. They are don't-care when `o_valid`=0 but must not be X after reset.
- Decode must hold `i_ready` independent of `o_valid`. Fetch never depends combinationally on `i_ready` except through `pop`.

## Timing
- Reset values:
  - `pc_q`=RESET_PC, so `o_imem_addr`=RESET_PC.
  - count=0, `o_valid`=0.
  - `o_inst`=0, `o_pc`=0 (storage cleared).
  - `o_misalign`=0, `o_misalign_pc`=0.
- Reset assertion mid-operation clears all state immediately (asynchronously).
- Fetch-to-valid latency:
  - The word addressed in cycle N is pushed at the end of cycle N.
  - `o_valid`=1 in cycle N+1.
- First instruction after reset release: `o_valid` rises one cycle after the first rising edge with `i_rst_n`=1.
- Redirect in cycle N:
  - `o_imem_addr`=target in N+1.
  - Target instruction is valid in N+2.
  - Redirect penalty is 2 cycles.
- Throughput with `i_ready` held at 1: one instruction per cycle, no bubbles.
- Back-to-back redirects: the last one wins; each flushes.

## Configuration
Macro: `INST_FETCH_MISALIGN_TRAP_EN`.

Defined:
- A redirect whose target has bits[1:0] ≠ 0 still loads `pc_q` and flushes.
- On the next edge it also sets `o_misalign`=1 and `o_misalign_pc`=target.
- Fetch halts: no pushes while `o_misalign`=1; entries already queued can still pop.
- A later redirect to an aligned target clears `o_misalign` and resumes fetching.
- A later redirect to a misaligned target updates `o_misalign_pc`.

Undefined:
- Redirect target bits[1:0] are forced to 0 before loading `pc_q`.
- `o_misalign` and `o_misalign_pc` are tied to 0.
- The halt logic is absent.

## Test plan
- Reset, RESET_PC=0x0, memory holds word i at address 4i, `i_ready`=1 → `o_valid` rises one cycle after release; `o_pc` sequence 0x0,0x4,0x8… with matching `o_inst`, one per cycle.
- `i_ready`=0 for 5 cycles → count saturates at DEPTH, `o_imem_addr` holds at 0x8. Then `i_ready`=1 → pops 0x0,0x4,0x8… with no skips or duplicates.
- Queue full, `i_ready`=1 constantly → simultaneous push/pop each cycle; count stays at DEPTH and order is preserved.
- Redirect to 0x100 while 2 entries are queued and `i_ready`=1 → `o_valid`=0 that cycle, no pop; `o_imem_addr`=0x100 next cycle; the first valid `o_pc` is 0x100, exactly 2 cycles after the redirect.
- ADDR_W=8, redirect to 0xFC → `o_pc` 0xFC then 0x00 (wrap).
- With the macro: redirect to 0x102 → `o_misalign`=1 and `o_misalign_pc`=0x102 next cycle, no new pushes; redirect to 0x200 clears it and fetch resumes. Without the macro: redirect to 0x102 → first `o_pc`=0x100 and `o_misalign` stays 0.
